inst_fetch_bus: RTL and testbench

Instruction-fetch bus adapter between the PC register and the IF/ID pipeline register. It turns each PC value into a req/ack read transaction on the instruction bus and holds the PC via `stallreq` while the read is outstanding. It delivers the fetched word to IF/ID, buffering it when the pipeline is stalled, and discards in-flight reads on flush.

---
 rtl/inst_fetch_bus_pkg.sv | 20 ++
 rtl/inst_fetch_bus.sv | 113 +++++++++++
 tb/tb_inst_fetch_bus.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_bus_pkg.sv
// rtl/inst_fetch_bus_pkg.sv - shared state encodings and constants for the fetch bus adapter
package inst_fetch_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NopInst    = 32'h0000_0000;
  localparam logic        ChipEnable = 1'b1;
  localparam logic        Stop       = 1'b1;
  localparam int          StallIfId  = 1;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_bus.sv
// rtl/inst_fetch_bus.sv - PC to req/ack instruction-bus adapter with IF/ID hold buffer
// One outstanding read at a time; flush abandons the data but still waits out the ack.
module inst_fetch_bus
  import inst_fetch_bus_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        stallreq,
  output logic [31:0] inst_o,
  output logic        exc_adel_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_data_i
);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_buf_q, inst_buf_d;

  logic ifid_stall;
  logic unused_stall_bits;

  assign ifid_stall        = stall[StallIfId];
  assign unused_stall_bits = ^{stall[5:2], stall[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      inst_buf_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    inst_buf_d = inst_buf_q;
    stallreq   = 1'b0;
    inst_o     = NOP_INST;
    exc_adel_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        exc_adel_o = (ce_i == ChipEnable) && !word_aligned(pc_i);
        if ((ce_i == ChipEnable) && !flush && word_aligned(pc_i)) begin
          stallreq = 1'b1;
          state_d  = ST_BUSY;
          req_d    = 1'b1;
          addr_d   = pc_i;
        end
      end

      ST_BUSY: begin
        if (bus_ack_i) begin
          // The ack cycle releases the PC and IF/ID, even when flushing.
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (!flush) begin
            inst_o     = bus_data_i;
            inst_buf_d = bus_data_i;
            if (ifid_stall == Stop) begin
              state_d = ST_HOLD;
            end
          end
        end else begin
          stallreq = 1'b1;
          if (flush) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_HOLD: begin
        inst_o = inst_buf_q;
        if (flush || (ifid_stall != Stop)) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        stallreq = 1'b1;
        if (bus_ack_i) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus_req_o  = req_q;
  assign bus_addr_o = addr_q;

endmodule

// File: tb/tb_inst_fetch_bus.sv
// tb/tb_inst_fetch_bus.sv - directed vector table plus randomized model check for inst_fetch_bus
module tb_inst_fetch_bus;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq;
  logic [31:0] inst_o;
  logic        exc_adel_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;

  int total = 0;
  int bad   = 0;

  inst_fetch_bus dut (
    .clk       (clk),
    .rst       (rst),
    .pc_i      (pc_i),
    .ce_i      (ce_i),
    .stall     (stall),
    .flush     (flush),
    .stallreq  (stallreq),
    .inst_o    (inst_o),
    .exc_adel_o(exc_adel_o),
    .bus_req_o (bus_req_o),
    .bus_addr_o(bus_addr_o),
    .bus_ack_i (bus_ack_i),
    .bus_data_i(bus_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        s1;
    logic        fl;
    logic        ack;
    logic [31:0] data;
    logic        e_stallreq;
    logic [31:0] e_inst;
    logic        e_adel;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ce, input logic [31:0] pc, input logic s1,
                     input logic fl, input logic ack, input logic [31:0] data,
                     input logic es, input logic [31:0] ei, input logic ea,
                     input logic er, input logic [31:0] ead);
    vec_t v;
    v.rst = r; v.ce = ce; v.pc = pc; v.s1 = s1; v.fl = fl; v.ack = ack; v.data = data;
    v.e_stallreq = es; v.e_inst = ei; v.e_adel = ea; v.e_req = er; v.e_addr = ead;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ce, input logic [31:0] pc, input logic s1,
                       input logic fl, input logic ack, input logic [31:0] data);
    rst = r; ce_i = ce; pc_i = pc; flush = fl; bus_ack_i = ack; bus_data_i = data;
    stall = {4'b0, s1, 1'b0};
  endtask

  task automatic check_all(input int idx, input logic es, input logic [31:0] ei,
                           input logic ea, input logic er, input logic [31:0] ead);
    chk("stallreq", idx, {31'b0, stallreq}, {31'b0, es});
    chk("inst_o", idx, inst_o, ei);
    chk("exc_adel_o", idx, {31'b0, exc_adel_o}, {31'b0, ea});
    chk("bus_req_o", idx, {31'b0, bus_req_o}, {31'b0, er});
    chk("bus_addr_o", idx, bus_addr_o, ead);
  endtask

  task automatic reset_dut();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Transaction-level reference: an outstanding read (possibly doomed), or a held word.
  logic        m_out, m_disc, m_held;
  logic [31:0] m_addr, m_word;

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //   rst ce pc            s1 fl ack data           sr inst           adel req addr
    // zero-wait fetches
    add(0, 1, 32'h00, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h00);
    add(0, 1, 32'h00, 0, 0, 1, 32'h3C010001,   0, 32'h3C010001,   0, 1, 32'h00);
    add(0, 1, 32'h04, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h00);
    add(0, 1, 32'h04, 0, 0, 1, 32'h34210002,   0, 32'h34210002,   0, 1, 32'h04);
    add(0, 1, 32'h08, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h04);
    add(0, 1, 32'h08, 0, 0, 1, 32'h00000000,   0, 32'h00000000,   0, 1, 32'h08);
    // three wait states
    add(0, 1, 32'h0C, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h08);
    add(0, 1, 32'h0C, 0, 0, 0, 32'h0,          1, 32'h0,          0, 1, 32'h0C);
    add(0, 1, 32'h0C, 0, 0, 0, 32'h0,          1, 32'h0,          0, 1, 32'h0C);
    add(0, 1, 32'h0C, 0, 0, 0, 32'h0,          1, 32'h0,          0, 1, 32'h0C);
    add(0, 1, 32'h0C, 0, 0, 1, 32'hDEADBEEF,   0, 32'hDEADBEEF,   0, 1, 32'h0C);
    // downstream stall during ack -> hold
    add(0, 1, 32'h10, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0C);
    add(0, 1, 32'h10, 1, 0, 1, 32'h12345678,   0, 32'h12345678,   0, 1, 32'h10);
    add(0, 1, 32'h14, 1, 0, 0, 32'h0,          0, 32'h12345678,   0, 0, 32'h10);
    add(0, 1, 32'h14, 1, 0, 1, 32'h55555555,   0, 32'h12345678,   0, 0, 32'h10);
    add(0, 1, 32'h14, 0, 0, 0, 32'h0,          0, 32'h12345678,   0, 0, 32'h10);
    // flush while busy without ack -> drain
    add(0, 1, 32'h14, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h10);
    add(0, 1, 32'h14, 0, 1, 0, 32'h0,          1, 32'h0,          0, 1, 32'h14);
    add(0, 1, 32'h20, 0, 0, 0, 32'h0,          1, 32'h0,          0, 1, 32'h14);
    add(0, 1, 32'h20, 0, 0, 1, 32'hAAAA5555,   1, 32'h0,          0, 1, 32'h14);
    add(0, 1, 32'h20, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h14);
    add(0, 1, 32'h20, 0, 0, 1, 32'h11111111,   0, 32'h11111111,   0, 1, 32'h20);
    // misaligned pc, stray ack ignored
    add(0, 1, 32'h06, 0, 0, 0, 32'h0,          0, 32'h0,          1, 0, 32'h20);
    add(0, 1, 32'h06, 0, 0, 1, 32'h99999999,   0, 32'h0,          1, 0, 32'h20);
    add(0, 0, 32'h06, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h20);
    // reset mid-transaction
    add(0, 1, 32'h24, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h20);
    add(1, 1, 32'h24, 0, 0, 0, 32'h0,          1, 32'h0,          0, 1, 32'h24);
    add(0, 0, 32'h24, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h00);
    // flush beats stall in hold
    add(0, 1, 32'h28, 1, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h00);
    add(0, 1, 32'h28, 1, 0, 1, 32'hCAFEF00D,   0, 32'hCAFEF00D,   0, 1, 32'h28);
    add(0, 0, 32'h28, 1, 1, 0, 32'h0,          0, 32'hCAFEF00D,   0, 0, 32'h28);
    add(0, 0, 32'h28, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h28);
    // flush coinciding with ack discards data; flush in idle blocks the fetch
    add(0, 1, 32'h30, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h28);
    add(0, 1, 32'h30, 1, 1, 1, 32'h77777777,   0, 32'h0,          0, 1, 32'h30);
    add(0, 0, 32'h30, 1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h30);
    add(0, 1, 32'h40, 0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h30);
    add(0, 0, 32'h40, 0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h30);

    reset_dut();
    check_all(-1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].s1, vecs[i].fl, vecs[i].ack,
            vecs[i].data);
      #1;
      check_all(i, vecs[i].e_stallreq, vecs[i].e_inst, vecs[i].e_adel, vecs[i].e_req,
                vecs[i].e_addr);
      @(posedge clk);
      #1;
    end

    reset_dut();
    m_out = 0; m_disc = 0; m_held = 0; m_addr = 32'h0; m_word = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r, ce, s1, fl, ack;
      logic [31:0] pc, data;
      logic        es, ea, er;
      logic [31:0] ei, ead;
      r    = ($urandom_range(0, 199) == 0);
      ce   = ($urandom_range(0, 9) != 0);
      pc   = $urandom;
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      s1   = ($urandom_range(0, 2) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      ack  = $urandom_range(0, 1) == 1;
      data = $urandom;

      es = 0; ei = 32'h0; ea = 0; er = m_out; ead = m_addr;
      if (m_out && !m_disc) begin
        if (ack) begin
          ei = fl ? 32'h0 : data;
          if (!fl && s1) begin
            m_held = 1; m_word = data;
          end
          m_out = 0;
        end else begin
          es = 1;
          if (fl) m_disc = 1;
        end
      end else if (m_out) begin
        es = 1;
        if (ack) begin
          m_out = 0; m_disc = 0;
        end
      end else if (m_held) begin
        ei = m_word;
        if (!s1 || fl) m_held = 0;
      end else begin
        ea = ce && (pc[1:0] != 2'b00);
        if (ce && !fl && pc[1:0] == 2'b00) begin
          es = 1; m_out = 1; m_addr = pc;
        end
      end
      if (r) begin
        m_out = 0; m_disc = 0; m_held = 0; m_addr = 32'h0;
      end

      drive(r, ce, pc, s1, fl, ack, data);
      #1;
      check_all(1000 + cyc, es, ei, ea, er, ead);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
